// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for a 5-stage RISC-V pipe: E-stage forwarding, load-use stall, branch flush,
// plus a per-register scoreboard for long-latency writebacks. Optional stall counter: HAZARD_STALL_CNT_EN.

module hazardFwdSel #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        fwd
);
    // M is the younger producer, so it takes priority over W
    always_comb begin
        fwd = 2'b00;
        if (reg_write_m && rd_m != '0 && rd_m == rs)
            fwd = 2'b10;
        else if (reg_write_w && rd_w != '0 && rd_w == rs)
            fwd = 2'b01;
    end
endmodule

module hazard_scoreboard_unit #(
    parameter int REG_AW   = 5,
    parameter int MAX_PEND = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [REG_AW-1:0]            rs1_d,
    input  logic [REG_AW-1:0]            rs2_d,
    input  logic [REG_AW-1:0]            rd_d,
    input  logic                         lng_op_d,
    input  logic [REG_AW-1:0]            rs1_e,
    input  logic [REG_AW-1:0]            rs2_e,
    input  logic [REG_AW-1:0]            rd_e,
    input  logic                         result_src_e0,
    input  logic                         pc_src_e,
    input  logic                         lng_issue_e,
    input  logic [REG_AW-1:0]            rd_m,
    input  logic [REG_AW-1:0]            rd_w,
    input  logic                         reg_write_m,
    input  logic                         reg_write_w,
    input  logic                         lng_done,
    input  logic [REG_AW-1:0]            lng_rd,
    output logic                         stall_f,
    output logic                         stall_d,
    output logic                         flush_d,
    output logic                         flush_e,
    output logic [1:0]                   forward_ae,
    output logic [1:0]                   forward_be,
    output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt,
    output logic                         sb_err,
    output logic [31:0]                  stall_cycles
);
    localparam int NREG = 2**REG_AW;
    localparam int CW   = $clog2(MAX_PEND+1);

    logic [NREG-1:0]         sb, sbNext;
    logic [CW-1:0]           pendCnt;
    logic                    sbErr;
    logic                    pendFull, lwStall, sbStall, anyStall, doneBad, issueValid;
    logic [1:0][REG_AW-1:0]  srcE;
    logic [1:0][1:0]         fwdSel;

    assign srcE = {rs2_e, rs1_e};

    for (genvar i = 0; i < 2; i++) begin : gFwd
        hazardFwdSel #(.REG_AW(REG_AW)) uFwd (
            .rs          (srcE[i]),
            .rd_m        (rd_m),
            .rd_w        (rd_w),
            .reg_write_m (reg_write_m),
            .reg_write_w (reg_write_w),
            .fwd         (fwdSel[i])
        );
    end

    assign forward_ae = fwdSel[0];
    assign forward_be = fwdSel[1];

    assign issueValid = lng_issue_e && rd_e != '0;
    assign pendFull   = pendCnt == CW'(MAX_PEND);

    // Clear first, then set: a same-cycle issue to the retiring register is the younger op
    always_comb begin
        sbNext = sb;
        if (lng_done)
            sbNext[lng_rd] = 1'b0;
        if (issueValid)
            sbNext[rd_e] = 1'b1;
        sbNext[0] = 1'b0;
    end

    assign doneBad = lng_done && (lng_rd == '0 || !sb[lng_rd])
                     && !(issueValid && rd_e == lng_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb      <= '0;
            pendCnt <= '0;
            sbErr   <= 1'b0;
        end else begin
            sb <= sbNext;
            if (lng_issue_e && !lng_done && !pendFull)
                pendCnt <= pendCnt + CW'(1);
            else if (lng_done && !lng_issue_e && pendCnt != '0)
                pendCnt <= pendCnt - CW'(1);
            if (doneBad)
                sbErr <= 1'b1;
        end
    end

    // Decode sees only registered scoreboard state; a same-cycle lng_done releases next cycle
    assign lwStall  = result_src_e0 && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
    assign sbStall  = sb[rs1_d] || sb[rs2_d] || (sb[rd_d] && rd_d != '0) || (lng_op_d && pendFull);
    assign anyStall = lwStall || sbStall;

    assign stall_f  = anyStall;
    assign stall_d  = anyStall;
    assign flush_e  = anyStall || pc_src_e;
    assign flush_d  = pc_src_e;
    assign pend_cnt = pendCnt;
    assign sb_err   = sbErr;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stallCnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stallCnt <= '0;
        else if (anyStall)
            stallCnt <= stallCnt + 32'd1;
    end
    assign stall_cycles = stallCnt;
`else
    assign stall_cycles = '0;
`endif

endmodule
